// File: rtl/icache_dm_if.sv
// CPU fetch port and byte-wide memory read port of the direct-mapped instruction cache.
// The slave modport is the cache side; master is the CPU plus memory controller.
interface icache_dm_if #(
  parameter int unsigned ADDR_L   = 32,
  parameter int unsigned M_DATA_L = 8,
  parameter int unsigned C_DATA_L = 32
);
  logic                c_re;
  logic [ADDR_L-1:0]   c_raddr;
  logic                c_flush;
  logic [C_DATA_L-1:0] c_dout;
  logic                c_rack;
  logic                m_re;
  logic [ADDR_L-1:0]   m_raddr;
  logic [M_DATA_L-1:0] m_din;
  logic                m_rack;

  modport master (
    output c_re, c_raddr, c_flush,
    input  c_dout, c_rack,
    input  m_re, m_raddr,
    output m_din, m_rack
  );

  modport slave (
    input  c_re, c_raddr, c_flush,
    output c_dout, c_rack,
    output m_re, m_raddr,
    input  m_din, m_rack
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, one word per line, filled byte by byte from memory.
// Flushes requested while a fill or response is in flight are applied on the return to IDLE.
module icache_dm #(
  parameter int unsigned ADDR_L   = 32,
  parameter int unsigned M_DATA_L = 8,
  parameter int unsigned C_DATA_L = 32,
  parameter int unsigned LINES    = 16
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
);
  localparam int unsigned IDX_L = $clog2(LINES);
  localparam int unsigned OFS_L = 2;
  localparam int unsigned TAG_L = ADDR_L - OFS_L - IDX_L;
  localparam int unsigned BYTES = C_DATA_L / M_DATA_L;
  localparam int unsigned K_L   = $clog2(BYTES);
  localparam logic [K_L-1:0] K_LAST = K_L'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_L-1:0]    tag_mem  [LINES];
  logic [C_DATA_L-1:0] data_mem [LINES];

  logic [ADDR_L-1:0]   base_q, base_d;
  logic [K_L-1:0]      k_q, k_d;
  logic [C_DATA_L-1:0] buf_q, buf_d, fill_word;
  logic                m_re_q, m_re_d;
  logic [ADDR_L-1:0]   m_raddr_q, m_raddr_d;
  logic [C_DATA_L-1:0] c_dout_q, c_dout_d;
  logic                c_rack_q, c_rack_d;
  logic                flush_pend_q, flush_pend_d;
  logic                flush_all, line_we;

  logic [IDX_L-1:0]    req_idx, fill_idx;
  logic [TAG_L-1:0]    req_tag, fill_tag;
  logic [ADDR_L-1:0]   req_base;
  logic                hit;

  assign req_idx  = bus.c_raddr[OFS_L +: IDX_L];
  assign req_tag  = bus.c_raddr[ADDR_L-1 -: TAG_L];
  assign req_base = {bus.c_raddr[ADDR_L-1:OFS_L], {OFS_L{1'b0}}};
  assign fill_idx = base_q[OFS_L +: IDX_L];
  assign fill_tag = base_q[ADDR_L-1 -: TAG_L];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign bus.c_dout  = c_dout_q;
  assign bus.c_rack  = c_rack_q;
  assign bus.m_re    = m_re_q;
  assign bus.m_raddr = m_raddr_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      k_q          <= '0;
      base_q       <= '0;
      buf_q        <= '0;
      c_rack_q     <= 1'b0;
      c_dout_q     <= '0;
      m_re_q       <= 1'b0;
      m_raddr_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      k_q          <= k_d;
      base_q       <= base_d;
      buf_q        <= buf_d;
      c_rack_q     <= c_rack_d;
      c_dout_q     <= c_dout_d;
      m_re_q       <= m_re_d;
      m_raddr_q    <= m_raddr_d;
      if (flush_all) begin
        valid_q <= '0;
      end else if (line_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_word;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.c_flush && bus.c_re) state_d = hit ? RESP : FILL;
      FILL: if (bus.m_rack && (k_q == K_LAST)) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    base_d       = base_q;
    k_d          = k_q;
    buf_d        = buf_q;
    m_re_d       = m_re_q;
    m_raddr_d    = m_raddr_q;
    c_dout_d     = c_dout_q;
    c_rack_d     = 1'b0;
    flush_pend_d = flush_pend_q | bus.c_flush;
    flush_all    = 1'b0;
    line_we      = 1'b0;
    fill_word    = buf_q;
    fill_word[32'(k_q) * M_DATA_L +: M_DATA_L] = bus.m_din;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (bus.c_flush) begin
          flush_all = 1'b1;
        end else if (bus.c_re) begin
          if (hit) begin
            c_dout_d = data_mem[req_idx];
            c_rack_d = 1'b1;
          end else begin
            base_d    = req_base;
            k_d       = '0;
            m_re_d    = 1'b1;
            m_raddr_d = req_base;
          end
        end
      end
      FILL: begin
        if (bus.m_rack) begin
          buf_d = fill_word;
          if (k_q != K_LAST) begin
            k_d       = k_q + K_L'(1);
            m_raddr_d = base_q + ADDR_L'(k_q) + ADDR_L'(1);
          end else begin
            m_re_d   = 1'b0;
            line_we  = 1'b1;
            c_dout_d = fill_word;
            c_rack_d = 1'b1;
          end
        end
      end
      RESP: begin
        flush_all    = flush_pend_q | bus.c_flush;
        flush_pend_d = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_icache_dm.sv
// Randomized scoreboard bench for icache_dm: a memory responder and a response monitor
// check traffic against expectations queued by a simple cache-hit/memory reference model.
module tb_icache_dm;
  localparam int unsigned ADDR_L   = 32;
  localparam int unsigned M_DATA_L = 8;
  localparam int unsigned C_DATA_L = 32;
  localparam int unsigned LINES    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_dm_if #(.ADDR_L(ADDR_L), .M_DATA_L(M_DATA_L), .C_DATA_L(C_DATA_L)) bus ();

  icache_dm #(.ADDR_L(ADDR_L), .M_DATA_L(M_DATA_L), .C_DATA_L(C_DATA_L), .LINES(LINES))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mack_count = 0;
  int last_ack_cyc = 0;
  bit slow_mem = 1'b0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_resp_q [$];
  bit          model_valid [LINES];
  logic [25:0] model_tag   [LINES];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h10: return 8'h11;
      32'h11: return 8'h22;
      32'h12: return 8'h33;
      32'h13: return 8'h44;
      32'h50: return 8'hAA;
      32'h51: return 8'hBB;
      32'h52: return 8'hCC;
      32'h53: return 8'hDD;
      default: return 8'((a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3c);
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mem_rd(b + 32'd3), mem_rd(b + 32'd2), mem_rd(b + 32'd1), mem_rd(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(LINES); i++) model_valid[i] = 1'b0;
  endtask

  // Memory controller: variable latency, stable-address checks, spurious acks while idle
  initial begin : mem_resp
    bit          active;
    int          delay_left;
    logic [31:0] held;
    active = 1'b0;
    delay_left = 0;
    held = '0;
    bus.m_rack = 1'b0;
    bus.m_din  = '0;
    forever begin
      @(negedge clk);
      bus.m_rack = 1'b0;
      if (rst === 1'b1) begin
        active = 1'b0;
      end else if (bus.m_re === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          held = bus.m_raddr;
          delay_left = slow_mem ? 3 : int'($urandom_range(0, 2));
        end else begin
          check("m_raddr_stable", bus.m_raddr, held);
        end
        if (delay_left == 0) begin
          active = 1'b0;
          bus.m_rack = 1'b1;
          bus.m_din = mem_rd(bus.m_raddr);
          mack_count++;
          last_ack_cyc = cyc;
          if (exp_addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_read actual=%h expected=none", bus.m_raddr);
          end else begin
            check("m_raddr_seq", bus.m_raddr, exp_addr_q.pop_front());
          end
        end else begin
          delay_left--;
        end
      end else begin
        active = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          bus.m_rack = 1'b1;
          bus.m_din = 8'($urandom);
        end
      end
    end
  end

  // Response monitor
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (bus.c_rack === 1'b1) begin
        if (exp_resp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rack actual=%h expected=none", bus.c_dout);
        end else begin
          check("c_dout", bus.c_dout, exp_resp_q.pop_front());
        end
      end
    end
  end

  task automatic do_flush();
    bus.c_flush = 1'b1;
    @(negedge clk);
    bus.c_flush = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, input bit flush_mid, input bit rst_mid);
    logic [31:0] b;
    logic [3:0]  idx;
    logic [25:0] tag;
    logic [31:0] word;
    bit hit, got, flushed, rst_go;
    int start, n;
    b = {addr[31:2], 2'b00};
    idx = addr[5:2];
    tag = addr[31:6];
    word = mem_word(addr);
    hit = model_valid[idx] && (model_tag[idx] == tag);
    got = 1'b0;
    flushed = 1'b0;
    rst_go = 1'b0;
    start = mack_count;
    n = 0;
    if (!hit) for (int k = 0; k < 4; k++) exp_addr_q.push_back(b + 32'(k));
    if (!rst_mid) exp_resp_q.push_back(word);
    bus.c_raddr = addr;
    bus.c_re = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      bus.c_flush = 1'b0;
      if (bus.c_rack === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (rst_mid && (mack_count - start >= 2)) begin
        rst_go = 1'b1;
        break;
      end
      if (flush_mid && !flushed && (mack_count - start >= 1)) begin
        bus.c_flush = 1'b1;
        flushed = 1'b1;
      end
    end
    if (rst_go) begin
      @(negedge clk);
      rst = 1'b1;
      bus.c_re = 1'b0;
      @(negedge clk);
      check("m_re_after_rst", 32'(bus.m_re), 32'd0);
      check("c_rack_after_rst", 32'(bus.c_rack), 32'd0);
      rst = 1'b0;
      exp_addr_q.delete();
      model_clear();
      return;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL read_timeout actual=no_rack expected=rack addr=%h", addr);
      bus.c_re = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_addr_q.delete();
      exp_resp_q.delete();
      model_clear();
      return;
    end
    check("mem_reads", 32'(mack_count - start), hit ? 32'd0 : 32'd4);
    if (hit) check("hit_latency", 32'(n), 32'd1);
    else     check("miss_latency", 32'(cyc - last_ack_cyc), 32'd1);
    bus.c_re = 1'b0;
    @(negedge clk);
    check("rack_pulse", 32'(bus.c_rack), 32'd0);
    check("dout_hold", bus.c_dout, word);
    if (!hit) begin
      model_valid[idx] = 1'b1;
      model_tag[idx] = tag;
    end
    if (flushed) model_clear();
  endtask

  initial begin : main
    int r;
    logic [31:0] a;
    model_clear();
    rst = 1'b1;
    bus.c_re = 1'b0;
    bus.c_raddr = '0;
    bus.c_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_c_rack", 32'(bus.c_rack), 32'd0);
    check("rst_m_re", 32'(bus.m_re), 32'd0);
    check("rst_c_dout", bus.c_dout, 32'd0);
    check("rst_m_raddr", bus.m_raddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_read(32'h10, 1'b0, 1'b0);
    check("cold_word", mem_word(32'h10), 32'h44332211);
    do_read(32'h12, 1'b0, 1'b0);
    do_read(32'h50, 1'b0, 1'b0);
    do_read(32'h10, 1'b0, 1'b0);
    do_flush();
    do_read(32'h10, 1'b0, 1'b0);
    do_flush();
    do_read(32'h10, 1'b1, 1'b0);
    do_read(32'h10, 1'b0, 1'b0);

    slow_mem = 1'b1;
    do_read(32'h14, 1'b0, 1'b1);
    do_read(32'h14, 1'b0, 1'b0);
    do_read(32'h16, 1'b0, 1'b0);
    do_read(32'h98, 1'b0, 1'b0);
    slow_mem = 1'b0;

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 11));
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      if (r == 0) do_flush();
      else do_read(a, r == 1, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
